// File: rtl/bus_stream_ram_if.sv
// Control/status side of the memory slave bus; the bidirectional data bus is a
// separate inout port on the slave itself.
interface bus_stream_ram_if #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic                  rd;
  logic                  wr;
  logic                  clr;
  logic [ADDR_W-1:0]     addr;
  logic [DEPTH_LOG2:0]   level;
  logic                  full;
  logic                  empty;
  logic                  ovf;
  logic                  unf;

  modport master (output rd, wr, clr, addr, input level, full, empty, ovf, unf);
  modport slave  (input rd, wr, clr, addr, output level, full, empty, ovf, unf);
endinterface

// File: rtl/bus_stream_ram.sv
// Parametrised memory slave: MODE=0 auto-increment stream FIFO with prefetch,
// MODE=1 RAM indexed by the low ADDR bits with one cycle read latency.
module bus_stream_ram #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned MODE       = 0,
  parameter int unsigned INIT_IDENT = 1,
  parameter int unsigned PREFILL    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_stream_ram_if.slave      bus,
  inout  wire  [DATA_W-1:0]    data
);
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] idx_t;
  typedef logic [DEPTH_LOG2:0]   lvl_t;

  localparam lvl_t LEVEL_RST = (MODE == 0 && PREFILL != 0) ? lvl_t'(DEPTH) : '0;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;

  idx_t              rptr, xptr, rptr_nxt, xptr_nxt;
  idx_t              aidx, widx, ridx;
  lvl_t              level, level_nxt;
  logic [DATA_W-1:0] dout, dout_nxt, wdata, rword;
  logic [ADDR_W-1:0] addr;
  logic              ovf, unf, full, empty, rd_acc, wr_acc, we;
  logic              unused_addr;

  assign addr        = bus.addr;
  assign aidx        = addr[DEPTH_LOG2-1:0];
  assign unused_addr = ^addr;

  assign full   = (MODE == 0) && (level == lvl_t'(DEPTH));
  assign empty  = (MODE == 0) && (level == '0);
  assign rd_acc = bus.rd && !empty;
  assign wr_acc = bus.wr && (!full || rd_acc);
  // With RD high the bus carries our own DOUT, so that is the value written.
  assign wdata  = bus.rd ? dout : data;
  assign data   = bus.rd ? dout : 'z;

  always_comb begin
    rptr_nxt  = rptr;
    xptr_nxt  = xptr;
    level_nxt = level;
    if (MODE == 0) begin
      if (rd_acc) rptr_nxt = rptr + idx_t'(1);
      if (wr_acc) xptr_nxt = xptr + idx_t'(1);
      if (wr_acc && !rd_acc)      level_nxt = level + lvl_t'(1);
      else if (rd_acc && !wr_acc) level_nxt = level - lvl_t'(1);
    end
    widx = (MODE == 0) ? xptr : aidx;
    ridx = (MODE == 0) ? rptr_nxt : aidx;
    we   = wr_acc && !bus.clr && !rst;
    // Unwritten words read as their own index; written bits power up clear.
    rword    = (INIT_IDENT != 0 && !written[ridx]) ? DATA_W'(ridx) : mem[ridx];
    dout_nxt = (we && widx == ridx) ? wdata : rword;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      xptr  <= '0;
      level <= LEVEL_RST;
      dout  <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (bus.clr) begin
      rptr  <= '0;
      xptr  <= '0;
      level <= LEVEL_RST;
      dout  <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      rptr  <= rptr_nxt;
      xptr  <= xptr_nxt;
      level <= level_nxt;
      dout  <= dout_nxt;
      ovf   <= ovf | (bus.wr && !wr_acc);
      unf   <= unf | (bus.rd && empty);
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx]     <= wdata;
      written[widx] <= 1'b1;
    end
  end

  assign bus.level = level;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.ovf   = ovf;
  assign bus.unf   = unf;
endmodule

// File: tb/tb_bus_stream_ram.sv
// Scoreboarded bench: two stream instances (prefilled / empty) share stimulus,
// one addressed instance runs alongside; a ring/array model predicts each cycle.
module tb_bus_stream_ram;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s_rd = 0, s_wr = 0, s_clr = 0;
  logic [15:0] s_wd = '0;
  logic        a_rd = 0, a_wr = 0;
  logic [15:0] a_addr = '0, a_wd = '0;

  wire [15:0] da, db, dc;

  bus_stream_ram_if #(.ADDR_W(16), .DEPTH_LOG2(4)) ifa ();
  bus_stream_ram_if #(.ADDR_W(16), .DEPTH_LOG2(4)) ifb ();
  bus_stream_ram_if #(.ADDR_W(16), .DEPTH_LOG2(4)) ifc ();

  assign ifa.rd = s_rd;  assign ifa.wr = s_wr;  assign ifa.clr = s_clr;  assign ifa.addr = '0;
  assign ifb.rd = s_rd;  assign ifb.wr = s_wr;  assign ifb.clr = s_clr;  assign ifb.addr = '0;
  assign ifc.rd = a_rd;  assign ifc.wr = a_wr;  assign ifc.clr = 1'b0;   assign ifc.addr = a_addr;

  assign da = s_rd ? 'z : s_wd;
  assign db = s_rd ? 'z : s_wd;
  assign dc = a_rd ? 'z : a_wd;

  bus_stream_ram #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(4), .MODE(0), .INIT_IDENT(1), .PREFILL(1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa), .data(da));
  bus_stream_ram #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(4), .MODE(0), .INIT_IDENT(1), .PREFILL(0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb), .data(db));
  bus_stream_ram #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(4), .MODE(1), .INIT_IDENT(1), .PREFILL(1))
    dut_c (.clk(clk), .rst(rst), .bus(ifc), .data(dc));

  typedef struct {
    int unsigned dut;
    bit          chk;
    logic [15:0] data;
    logic [4:0]  level;
    bit          full, empty, ovf, unf;
  } exp_t;
  exp_t sb[$];

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference: stream contents as a ring of 16 words, read index and count;
  // the write slot is always (read index + count) mod 16.
  logic [15:0] sm [2][16];
  int unsigned s_rp [2], s_cnt [2];
  bit          s_ovf [2], s_unf [2], s_zero [2];
  logic [15:0] am [16];
  int unsigned a_pidx;
  bit          a_zero;

  function automatic int unsigned prefill_cnt(int unsigned i);
    return (i == 0) ? 16 : 0;
  endfunction

  task automatic stream_reset(input int unsigned i);
    s_rp[i] = 0; s_cnt[i] = prefill_cnt(i);
    s_ovf[i] = 0; s_unf[i] = 0; s_zero[i] = 1;
  endtask

  task automatic model_reset();
    stream_reset(0); stream_reset(1);
    a_zero = 1; a_pidx = 0;
  endtask

  task automatic cycle(input bit rd, input bit wr, input bit clr, input logic [15:0] wd,
                       input bit ard, input bit awr, input logic [15:0] aaddr, input logic [15:0] awd);
    exp_t e;
    logic [15:0] ex;
    bit racc, wacc;
    int unsigned idx;
    s_rd = rd; s_wr = wr; s_clr = clr; s_wd = wd;
    a_rd = ard; a_wr = awr; a_addr = aaddr; a_wd = awd;
    if (rst) model_reset();
    for (int unsigned i = 0; i < 2; i++) begin
      ex = s_zero[i] ? 16'h0000 : sm[i][s_rp[i]];
      e.dut = i; e.chk = rd; e.data = ex; e.level = 5'(s_cnt[i]);
      e.full = (s_cnt[i] == 16); e.empty = (s_cnt[i] == 0);
      e.ovf = s_ovf[i]; e.unf = s_unf[i];
      sb.push_back(e);
      if (!rst) begin
        if (clr) stream_reset(i);
        else begin
          racc = rd && (s_cnt[i] != 0);
          wacc = wr && ((s_cnt[i] != 16) || racc);
          if (wacc) sm[i][(s_rp[i] + s_cnt[i]) % 16] = rd ? ex : wd;
          if (rd && s_cnt[i] == 0) s_unf[i] = 1;
          if (wr && !wacc) s_ovf[i] = 1;
          if (racc) s_rp[i] = (s_rp[i] + 1) % 16;
          s_cnt[i] = s_cnt[i] + int'(wacc) - int'(racc);
          s_zero[i] = 0;
        end
      end
    end
    ex = a_zero ? 16'h0000 : am[a_pidx];
    e.dut = 2; e.chk = ard; e.data = ex; e.level = '0;
    e.full = 0; e.empty = 0; e.ovf = 0; e.unf = 0;
    sb.push_back(e);
    if (!rst) begin
      idx = int'(aaddr[3:0]);
      if (awr) am[idx] = ard ? ex : awd;
      a_pidx = idx; a_zero = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
  endtask

  task automatic chk(input string name, input int unsigned d, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut=%0d got=%h want=%h t=%0t", name, d, got, want, $time);
    end
  endtask

  // Monitor: every cycle the DUTs present status (and data while RD is high).
  always @(negedge clk) begin
    exp_t e;
    logic [4:0] lv;
    logic [3:0] fl;
    logic [15:0] dv;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        0: begin lv = ifa.level; fl = {ifa.full, ifa.empty, ifa.ovf, ifa.unf}; dv = da; end
        1: begin lv = ifb.level; fl = {ifb.full, ifb.empty, ifb.ovf, ifb.unf}; dv = db; end
        default: begin lv = ifc.level; fl = {ifc.full, ifc.empty, ifc.ovf, ifc.unf}; dv = dc; end
      endcase
      chk("level", e.dut, 16'(lv), 16'(e.level));
      chk("full",  e.dut, 16'(fl[3]), 16'(e.full));
      chk("empty", e.dut, 16'(fl[2]), 16'(e.empty));
      chk("ovf",   e.dut, 16'(fl[1]), 16'(e.ovf));
      chk("unf",   e.dut, 16'(fl[0]), 16'(e.unf));
      if (e.chk) chk("data", e.dut, dv, e.data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    for (int unsigned j = 0; j < 16; j++) begin
      sm[0][j] = 16'(j); sm[1][j] = 16'(j); am[j] = 16'(j);
    end
    model_reset();
    @(posedge clk); #1;
    idle(); idle();
    rst = 1'b0;

    // Drain the prefilled image, then one underflowing read and a clear.
    repeat (16) cycle(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    cycle(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    idle();
    cycle(0, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    idle();

    // Write while full, then simultaneous read+write.
    cycle(0, 1, 0, 16'hA5A5, 0, 0, 16'h0000, 16'h0000);
    cycle(1, 1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    idle();

    // Bypass into the prefetch register of the empty instance.
    cycle(0, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    cycle(0, 1, 0, 16'h1234, 0, 0, 16'h0000, 16'h0000);
    cycle(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    idle();

    // Addressed write through an aliased address, read back after latency.
    cycle(0, 0, 0, 16'h0000, 0, 1, 16'h0013, 16'hBEEF);
    cycle(0, 0, 0, 16'h0000, 0, 0, 16'h0003, 16'h0000);
    cycle(0, 0, 0, 16'h0000, 1, 0, 16'h0003, 16'h0000);
    cycle(0, 0, 0, 16'h0000, 1, 0, 16'h0013, 16'h0000);

    // Asynchronous reset with seven words stored in the empty-reset instance.
    cycle(0, 0, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    for (int unsigned k = 0; k < 7; k++) cycle(0, 1, 0, 16'(16'h0100 + k), 0, 0, 16'h0000, 16'h0000);
    idle();
    #1 rst = 1'b1;
    cycle(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    cycle(0, 1, 0, 16'h5555, 0, 0, 16'h0000, 16'h0000);
    rst = 1'b0;
    cycle(0, 1, 0, 16'h7777, 0, 0, 16'h0000, 16'h0000);
    cycle(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    idle();

    // Randomized traffic with occasional clears and asynchronous resets.
    for (int unsigned n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        #1 rst = 1'b1;
        idle();
        rst = 1'b0;
      end else begin
        cycle(1'($urandom), 1'($urandom), ($urandom_range(0, 31) == 0), 16'($urandom),
              1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      end
    end
    idle();

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
